msdap_output_collector: RTL and testbench
=========================================

// Module: msdap_output_collector
// PURPOSE
//  Downstream stage of the MSDAP core. Deserialises the two 40-bit MSB-first serial result streams
//  (OutputL/OutputR) that the core shifts out under OutReady. Buffers each L/R result pair in a
//  small FIFO and presents it to the host/bench over a valid/ready handshake.
//  Also keeps sample, overflow and framing-error status.
// PARAMETERS
//  WORD_W  40  width of one serial result word (bits per OutReady burst)
//  DEPTH   4   FIFO depth in L/R pairs (power of 2, >=2)
//  CNT_W   16  width of sample_count
// PORTS
//  Sclk          in   1         system clock; all logic on rising edge
//  Reset         in   1         synchronous, active-high reset
//  Frame         in   1         frame strobe from core; marks first (MSB) bit of a result
//  OutReady      in   1         high while OutputL/OutputR carry valid result bits
//  OutputL       in   1         left serial result bit, MSB first
//  OutputR       in   1         right serial result bit, MSB first
//  out_valid     out  1         FIFO head valid
//  out_ready     in   1         consumer accepts head when out_valid&out_ready
//  out_L         out  WORD_W    left result at FIFO head
//  out_R         out  WORD_W    right result at FIFO head
//  fifo_level    out  $clog2(DEPTH)+1  pairs currently stored
//  sample_count  out  CNT_W     completed pairs received (incl. dropped), wraps
//  overflow      out  1         sticky: a completed pair was dropped (FIFO full)
//  frame_err     out  1         sticky: OutReady fell before WORD_W bits
// BEHAVIOUR
//  - Reset: state=IDLE, bit_cnt=0, shift regs=0, FIFO empty, out_valid=0, out_L/out_R=0,
//    fifo_level=0, sample_count=0, overflow=0, frame_err=0. Reset mid-burst discards partial word.
//  - FSM IDLE: Frame&OutReady -> sample bit WORD_W-1 of both streams into shift regs,
//    bit_cnt=1, go SHIFT. OutReady without Frame is ignored in IDLE.
//  - FSM SHIFT: each cycle with OutReady=1 shifts in one bit (sreg <= {sreg[W-2:0],bit}),
//    bit_cnt++.
//    - When bit_cnt==WORD_W-1 and OutReady=1: last bit taken, go PUSH.
//    - OutReady=0 in SHIFT: abort, frame_err<=1, partial word discarded, go IDLE.
//    - Frame=1 in SHIFT (re-sync): treated as new MSB: restart with bit_cnt=1, frame_err<=1.
//  - FSM PUSH (1 cycle): write {sreg_L,sreg_R} to FIFO, sample_count++, go IDLE.
//    - If FIFO full and no pop this cycle: pair dropped, overflow<=1.
//    - Full with simultaneous pop: push accepted.
//    - Frame&OutReady in PUSH is latched as start of next word (goes SHIFT, bit_cnt=1).
//  - Latency: last serial bit at cycle N -> out_valid=1 at cycle N+2 when FIFO empty.
//  - FIFO: first-word fall-through; out_L/out_R valid whenever out_valid=1, held stable until
//    popped. Pop on out_valid&out_ready. Pop when empty is a no-op. Pointers wrap mod DEPTH.
//    fifo_level = push-pop net each cycle.
//  - sample_count wraps 2^CNT_W-1 -> 0. Sticky flags clear only on Reset.
//  - Data is passed bit-exact; no arithmetic on the 40-bit words.
// CONFIGURATION
//  OUTCOL_SAT16_EN defined: adds ports out_L16/out_R16 (out, 16).
//    - Each = signed saturation of out_X[39:16] (24-bit two's complement) to [-32768,32767].
//    - Combinational from FIFO head.
//  Undefined: those ports and the saturation logic do not exist; all else identical.
// STRUCTURE
//  msdap_pkg:
//    - OUTCOL_WORD_W=40
//    - typedef enum logic[1:0] {IDLE,SHIFT,PUSH} outcol_state_t
//    - function sat16(input logic signed [23:0])
//  Sub-module outcol_fifo: sync FWFT FIFO, params WIDTH=2*WORD_W, DEPTH;
//    ports Sclk, Reset, push, din, pop, dout, empty, full, level.
// TESTING
//  1. Frame+OutReady for 40 cycles, L=40'h80_0000_0001, R=40'hFF_FFFF_FFFE
//     -> out_valid 2 cycles after last bit, out_L/out_R exact, sample_count=1.
//  2. Five back-to-back pairs, out_ready=0
//     -> fifo_level=4, 5th dropped, overflow=1, sample_count=5; drain yields pairs 1-4 in order.
//  3. OutReady deasserted after 20 bits
//     -> frame_err=1, no push, fifo_level unchanged; next full burst captured correctly.
//  4. FIFO full, last bit of new pair arrives, out_ready=1 at PUSH
//     -> pop+push same cycle, level stays 4, overflow stays 0.
//  5. Reset asserted at bit 25 of a burst
//     -> all outputs 0 next cycle; subsequent burst captured correctly.
//  6. (OUTCOL_SAT16_EN) out_L=40'h01_0000_0000 -> out_L16=16'h7FFF;
//     40'hFF_8000_0000 -> 16'h8000; 40'h00_1234_0000 -> 16'h1234.

Source files
------------

// File: rtl/msdap_pkg.sv
// Shared types and helpers for the MSDAP output collector.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package msdap_pkg;

    localparam int OUTCOL_WORD_W = 40;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PUSH
    } outcol_state_t;

    // Clamp a 24-bit two's complement value into the signed 16-bit range.
    function automatic logic [15:0] sat16(input logic signed [23:0] x);
        logic [15:0] r;
        if (x > 24'sd32767) begin
            r = 16'h7FFF;
        end else if (x < -24'sd32768) begin
            r = 16'h8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/outcol_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible on dout whenever empty=0.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: a push while full is ignored unless a pop happens on the same edge.
module outcol_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic                     Sclk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign level  = count;
    assign doPop  = pop & ~empty;
    // When full, the slot being written is the one being popped on the same edge.
    assign doPush = push & (~full | doPop);
    // Show zero rather than stale storage while nothing is queued.
    assign dout   = empty ? '0 : mem[rdPtr];

    // Storage array; no reset needed because reads are masked while empty.
    always_ff @(posedge Sclk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msdap_output_collector.sv
// Deserialises the MSDAP L/R serial result streams and queues each pair; optional OUTCOL_SAT16_EN adds 16-bit saturated views.
// Latency: last serial bit at cycle N gives out_valid at cycle N+2 when the queue was empty.
// Backpressure: out_valid/out_ready pop; a completed pair arriving while full with no pop is dropped and flagged.
module msdap_output_collector
    import msdap_pkg::*;
#(
    parameter int WORD_W = OUTCOL_WORD_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     Sclk,
    input  logic                     Reset,
    input  logic                     Frame,
    input  logic                     OutReady,
    input  logic                     OutputL,
    input  logic                     OutputR,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        out_L,
    output logic [WORD_W-1:0]        out_R,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         sample_count,
    output logic                     overflow,
    output logic                     frame_err
`ifdef OUTCOL_SAT16_EN
    ,
    output logic [15:0]              out_L16,
    output logic [15:0]              out_R16
`endif
);

    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] BIT_LAST = CW'(WORD_W - 1);

    outcol_state_t       state;
    outcol_state_t       stateNext;
    logic [CW-1:0]       bitCnt;
    logic [CW-1:0]       bitCntNext;
    logic [WORD_W-1:0]   sregL;
    logic [WORD_W-1:0]   sregR;
    logic [WORD_W-1:0]   sregLNext;
    logic [WORD_W-1:0]   sregRNext;
    logic                pushReq;
    logic                setFrameErr;
    logic                popReq;
    logic                fifoEmpty;
    logic                fifoFull;
    logic [2*WORD_W-1:0] headDat;

    // Shift FSM state, bit counter and the two deserialising registers.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            state  <= IDLE;
            bitCnt <= '0;
            sregL  <= '0;
            sregR  <= '0;
        end else begin
            state  <= stateNext;
            bitCnt <= bitCntNext;
            sregL  <= sregLNext;
            sregR  <= sregRNext;
        end
    end

    // Next-state logic: a Frame with OutReady always starts a fresh word with the MSB.
    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        sregLNext   = sregL;
        sregRNext   = sregR;
        pushReq     = 1'b0;
        setFrameErr = 1'b0;
        case (state)
            IDLE: begin
                if (Frame && OutReady) begin
                    sregLNext  = {{(WORD_W-1){1'b0}}, OutputL};
                    sregRNext  = {{(WORD_W-1){1'b0}}, OutputR};
                    bitCntNext = CW'(1);
                    stateNext  = SHIFT;
                end
            end
            SHIFT: begin
                if (!OutReady) begin
                    // Burst ended early: drop the partial word.
                    setFrameErr = 1'b1;
                    bitCntNext  = '0;
                    stateNext   = IDLE;
                end else if (Frame) begin
                    // Re-sync mid-word: this bit is the MSB of a new word.
                    setFrameErr = 1'b1;
                    sregLNext   = {{(WORD_W-1){1'b0}}, OutputL};
                    sregRNext   = {{(WORD_W-1){1'b0}}, OutputR};
                    bitCntNext  = CW'(1);
                end else begin
                    sregLNext = {sregL[WORD_W-2:0], OutputL};
                    sregRNext = {sregR[WORD_W-2:0], OutputR};
                    if (bitCnt == BIT_LAST) begin
                        bitCntNext = '0;
                        stateNext  = PUSH;
                    end else begin
                        bitCntNext = bitCnt + CW'(1);
                    end
                end
            end
            PUSH: begin
                pushReq = 1'b1;
                if (Frame && OutReady) begin
                    sregLNext  = {{(WORD_W-1){1'b0}}, OutputL};
                    sregRNext  = {{(WORD_W-1){1'b0}}, OutputR};
                    bitCntNext = CW'(1);
                    stateNext  = SHIFT;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                bitCntNext = '0;
                stateNext  = IDLE;
            end
        endcase
    end

    assign popReq = out_valid & out_ready;

    // Status: every completed pair counts, even when the queue drops it.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            sample_count <= '0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (pushReq) begin
                sample_count <= sample_count + CNT_W'(1);
                if (fifoFull && !popReq) begin
                    overflow <= 1'b1;
                end
            end
            if (setFrameErr) begin
                frame_err <= 1'b1;
            end
        end
    end

    outcol_fifo #(
        .WIDTH (2*WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Sclk  (Sclk),
        .Reset (Reset),
        .push  (pushReq),
        .din   ({sregL, sregR}),
        .pop   (popReq),
        .dout  (headDat),
        .empty (fifoEmpty),
        .full  (fifoFull),
        .level (fifo_level)
    );

    assign out_valid = ~fifoEmpty;
    assign out_L     = headDat[2*WORD_W-1:WORD_W];
    assign out_R     = headDat[WORD_W-1:0];

`ifdef OUTCOL_SAT16_EN
    // Saturated 16-bit views take the upper 24 bits of each head word.
    assign out_L16 = sat16(out_L[WORD_W-1:WORD_W-24]);
    assign out_R16 = sat16(out_R[WORD_W-1:WORD_W-24]);
`endif

endmodule

// File: tb/tb_msdap_output_collector.sv
// Directed bench for msdap_output_collector with a pair scoreboard.
// Latency: checks the N+2 valid timing and same-edge pop/push when full.
// Backpressure: exercises drop on full, pop-when-empty and draining order.
module tb_msdap_output_collector;

    logic        Sclk = 1'b0;
    logic        Reset;
    logic        Frame;
    logic        OutReady;
    logic        OutputL;
    logic        OutputR;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_L;
    logic [39:0] out_R;
    logic [2:0]  fifo_level;
    logic [15:0] sample_count;
    logic        overflow;
    logic        frame_err;
`ifdef OUTCOL_SAT16_EN
    logic [15:0] out_L16;
    logic [15:0] out_R16;
`endif

    int          checks = 0;
    int          passed = 0;
    int          expCount = 0;
    logic [79:0] sb[$];
    logic [79:0] expPair;
    logic [39:0] wl [5];
    logic [39:0] wr [5];
    logic [63:0] rnd;

    msdap_output_collector dut (
        .Sclk         (Sclk),
        .Reset        (Reset),
        .Frame        (Frame),
        .OutReady     (OutReady),
        .OutputL      (OutputL),
        .OutputR      (OutputR),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_L        (out_L),
        .out_R        (out_R),
        .fifo_level   (fifo_level),
        .sample_count (sample_count),
        .overflow     (overflow),
        .frame_err    (frame_err)
`ifdef OUTCOL_SAT16_EN
        ,
        .out_L16      (out_L16),
        .out_R16      (out_R16)
`endif
    );

    always #5 Sclk = ~Sclk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    // Drive nbits of a burst MSB first; the last bit is on the wires when this returns.
    task automatic sendBurst(input logic [39:0] l, input logic [39:0] r, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            tick();
            Frame    = (i == 0);
            OutReady = 1'b1;
            OutputL  = l[39-i];
            OutputR  = r[39-i];
        end
        if (nbits == 40) begin
            expCount++;
        end
    endtask

    // Let the last bit be sampled and drop the serial lines; the FSM is then in PUSH.
    task automatic endBurst();
        tick();
        Frame    = 1'b0;
        OutReady = 1'b0;
        OutputL  = 1'b0;
        OutputR  = 1'b0;
    endtask

    task automatic drain();
        logic [79:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("drain_valid", {79'b0, out_valid}, 80'd1);
            chk("drain_pair", {out_L, out_R}, e);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("drain_empty", {79'b0, out_valid}, 80'd0);
        chk("drain_level", {77'b0, fifo_level}, 80'd0);
    endtask

    task automatic newWord(output logic [39:0] w);
        rnd = {$urandom(), $urandom()};
        w   = rnd[39:0];
    endtask

    initial begin
        Reset     = 1'b1;
        Frame     = 1'b0;
        OutReady  = 1'b0;
        OutputL   = 1'b0;
        OutputR   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        Reset = 1'b0;

        // Reset state
        chk("rst_valid", {79'b0, out_valid}, 80'd0);
        chk("rst_pair", {out_L, out_R}, 80'd0);
        chk("rst_level", {77'b0, fifo_level}, 80'd0);
        chk("rst_count", {64'b0, sample_count}, 80'd0);
        chk("rst_overflow", {79'b0, overflow}, 80'd0);
        chk("rst_frame_err", {79'b0, frame_err}, 80'd0);

        // Pop while empty does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_pop_level", {77'b0, fifo_level}, 80'd0);
        chk("empty_pop_valid", {79'b0, out_valid}, 80'd0);

        // Single pair and N+2 latency
        sendBurst(40'h80_0000_0001, 40'hFF_FFFF_FFFE, 40);
        endBurst();
        chk("lat_push_cycle", {79'b0, out_valid}, 80'd0);
        tick();
        chk("lat_valid", {79'b0, out_valid}, 80'd1);
        chk("lat_count", {64'b0, sample_count}, 80'd1);
        chk("lat_level", {77'b0, fifo_level}, 80'd1);
        sb.push_back({40'h80_0000_0001, 40'hFF_FFFF_FFFE});
        drain();

        // Early OutReady drop after 20 bits
        sendBurst(40'hAA_5555_AAAA, 40'h12_3456_789A, 20);
        tick();
        Frame    = 1'b0;
        OutReady = 1'b0;
        tick();
        chk("ferr_flag", {79'b0, frame_err}, 80'd1);
        chk("ferr_level", {77'b0, fifo_level}, 80'd0);
        chk("ferr_count", {64'b0, sample_count}, 80'(expCount));
        sendBurst(40'h0F_F0F0_0F0F, 40'hC3_3C3C_C33C, 40);
        endBurst();
        tick();
        sb.push_back({40'h0F_F0F0_0F0F, 40'hC3_3C3C_C33C});
        chk("ferr_recover_count", {64'b0, sample_count}, 80'(expCount));
        drain();

        // Full queue with a pop on the same edge as the push
        for (int k = 0; k < 5; k++) begin
            newWord(wl[k]);
            newWord(wr[k]);
        end
        for (int k = 0; k < 4; k++) begin
            sendBurst(wl[k], wr[k], 40);
            sb.push_back({wl[k], wr[k]});
        end
        endBurst();
        tick();
        chk("full_level", {77'b0, fifo_level}, 80'd4);
        sendBurst(wl[4], wr[4], 40);
        endBurst();
        expPair = sb.pop_front();
        chk("full_head", {out_L, out_R}, expPair);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sb.push_back({wl[4], wr[4]});
        chk("popush_level", {77'b0, fifo_level}, 80'd4);
        chk("popush_overflow", {79'b0, overflow}, 80'd0);
        chk("popush_count", {64'b0, sample_count}, 80'(expCount));
        drain();

        // Five back-to-back pairs with no consumer: the fifth is dropped
        for (int k = 0; k < 5; k++) begin
            newWord(wl[k]);
            newWord(wr[k]);
        end
        for (int k = 0; k < 5; k++) begin
            sendBurst(wl[k], wr[k], 40);
            if (k < 4) begin
                sb.push_back({wl[k], wr[k]});
            end
        end
        endBurst();
        tick();
        chk("ovf_level", {77'b0, fifo_level}, 80'd4);
        chk("ovf_flag", {79'b0, overflow}, 80'd1);
        chk("ovf_count", {64'b0, sample_count}, 80'(expCount));
        drain();
        chk("ovf_sticky", {79'b0, overflow}, 80'd1);

        // Reset in the middle of a burst, with a pair queued
        sendBurst(40'h11_2233_4455, 40'h66_7788_99AA, 40);
        endBurst();
        tick();
        sendBurst(40'hDE_ADBE_EF01, 40'h01_EFBE_ADDE, 25);
        Reset = 1'b1;
        tick();
        chk("mrst_valid", {79'b0, out_valid}, 80'd0);
        chk("mrst_pair", {out_L, out_R}, 80'd0);
        chk("mrst_level", {77'b0, fifo_level}, 80'd0);
        chk("mrst_count", {64'b0, sample_count}, 80'd0);
        chk("mrst_overflow", {79'b0, overflow}, 80'd0);
        chk("mrst_frame_err", {79'b0, frame_err}, 80'd0);
        Reset    = 1'b0;
        Frame    = 1'b0;
        OutReady = 1'b0;
        sb.delete();
        expCount = 0;
        sendBurst(40'h5A_A5C3_3C96, 40'h69_9600_FF01, 40);
        endBurst();
        tick();
        sb.push_back({40'h5A_A5C3_3C96, 40'h69_9600_FF01});
        chk("mrst_recover_count", {64'b0, sample_count}, 80'd1);
        chk("mrst_recover_ferr", {79'b0, frame_err}, 80'd0);
        drain();

`ifdef OUTCOL_SAT16_EN
        // Saturated views of three head words
        sendBurst(40'h01_0000_0000, 40'hFF_FFFF_0000, 40);
        sendBurst(40'hFF_8000_0000, 40'h80_0000_0000, 40);
        sendBurst(40'h00_1234_0000, 40'h00_7FFF_FFFF, 40);
        endBurst();
        tick();
        chk("sat_l_pos", {64'b0, out_L16}, 80'h7FFF);
        chk("sat_r_m1", {64'b0, out_R16}, 80'hFFFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("sat_l_min", {64'b0, out_L16}, 80'h8000);
        chk("sat_r_neg", {64'b0, out_R16}, 80'h8000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("sat_l_pass", {64'b0, out_L16}, 80'h1234);
        chk("sat_r_max", {64'b0, out_R16}, 80'h7FFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
